// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder: Clause 22 MDIO management slave serving a 32 x 16-bit PHY register file.
// Latency: MDC edges are seen 3 clk after the pin, MDIO drive lags raw MDC fall by 4 clk, wr_valid 1 clk after the bit-31 rise.
// Backpressure: none; MDC paces every frame and each MDC phase must last at least 4 clk.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter int          PRE_LEN  = 32,
  parameter logic [15:0] PHY_ID1  = 16'h0141,
  parameter logic [15:0] PHY_ID2  = 16'h0DD1
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oen,
  input  logic        link_up,
  output logic [15:0] phy_ctrl,
  output logic        wr_valid,
  output logic [4:0]  wr_reg,
  output logic [15:0] wr_data,
  output logic        frame_err
);

  typedef enum logic [2:0] {S_IDLE, S_ST, S_OP, S_ADDR, S_TA, S_DATA} state_t;

  localparam logic [5:0] PRE_MAX = 6'(PRE_LEN);

  state_t      state, state_nxt;
  logic [2:0]  mdc_sync, mdio_sync;
  logic        rise, fall;
  logic        bit_val;
  logic [5:0]  pre_cnt;
  logic [4:0]  bit_idx;      // index of the most recently sampled frame bit
  logic [4:0]  cur_idx;      // index of the bit being sampled on this rise
  logic        op_b2;
  logic        op_rd;
  logic        match;
  logic        rd_drive;     // this frame is a matched read: we own the line from TA onward
  logic [8:0]  addr_sr;
  logic [9:0]  addr_full;
  logic [4:0]  reg_addr;
  logic [14:0] data_sr;
  logic [15:0] wdata;
  logic [15:0] snap;
  logic [15:0] rd_val;
  logic [15:0] rf [0:31];    // entries 0..3 are served by dedicated logic
  logic        commit;
  logic        err_nxt;
  logic        match_c;
  logic        writable;

  // Synchronise MDC/MDIO through two flops, keep a third stage and form one-cycle edge strobes.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      mdc_sync  <= 3'b000;
      mdio_sync <= 3'b000;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      mdc_sync  <= {mdc_sync[1:0], mdc};
      mdio_sync <= {mdio_sync[1:0], mdio_in};
      rise      <= mdc_sync[1] & ~mdc_sync[2];
      fall      <= ~mdc_sync[1] & mdc_sync[2];
    end
  end

  // The strobe is registered once more than the data tap, so stage 2 lines up with it.
  assign bit_val   = mdio_sync[2];
  assign cur_idx   = bit_idx + 5'd1;
  assign addr_full = {addr_sr, bit_val};
  assign match_c   = (addr_full[9:5] == PHY_ADDR);
  assign wdata     = {data_sr, bit_val};
  assign writable  = (reg_addr == 5'd0) || (reg_addr >= 5'd4);
  assign phy_ctrl  = rf[0];

  // Read mux for the register being addressed as REGAD completes.
  always_comb begin
    rd_val = rf[addr_full[4:0]];
    case (addr_full[4:0])
      5'd1:    rd_val = 16'h7949 | {13'd0, link_up, 2'b00};
      5'd2:    rd_val = PHY_ID1;
      5'd3:    rd_val = PHY_ID2;
      default: rd_val = rf[addr_full[4:0]];
    endcase
  end

  // Frame state register.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= S_IDLE;
    else             state <= state_nxt;
  end

  // Next state plus the frame-error and write-commit decisions, all taken on MDC rise.
  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    commit    = 1'b0;
    if (rise) begin
      case (state)
        S_IDLE: if (!bit_val && pre_cnt == PRE_MAX) state_nxt = S_ST;
        S_ST: begin
          if (bit_val) begin
            state_nxt = S_OP;
          end else begin
            state_nxt = S_IDLE;
            err_nxt   = 1'b1;
          end
        end
        S_OP: begin
          if (cur_idx == 5'd3) begin
            if (op_b2 != bit_val) begin
              state_nxt = S_ADDR;
            end else begin
              state_nxt = S_IDLE;
              err_nxt   = 1'b1;
            end
          end
        end
        S_ADDR: if (cur_idx == 5'd13) state_nxt = S_TA;
        S_TA:   if (cur_idx == 5'd15) state_nxt = S_DATA;
        S_DATA: begin
          if (cur_idx == 5'd31) begin
            state_nxt = S_IDLE;
            commit    = !op_rd && match && writable;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Frame datapath: preamble count, bit index, field shifters, snapshot and MDIO drive.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      pre_cnt   <= 6'd0;
      bit_idx   <= 5'd0;
      op_b2     <= 1'b0;
      op_rd     <= 1'b0;
      match     <= 1'b0;
      rd_drive  <= 1'b0;
      addr_sr   <= 9'd0;
      reg_addr  <= 5'd0;
      data_sr   <= 15'd0;
      snap      <= 16'd0;
      mdio_out  <= 1'b1;
      mdio_oen  <= 1'b1;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err_nxt;
      if (rise) begin
        bit_idx <= (state == S_IDLE) ? 5'd0 : cur_idx;
        if (state == S_IDLE && bit_val)
          pre_cnt <= (pre_cnt == PRE_MAX) ? pre_cnt : pre_cnt + 6'd1;
        else
          pre_cnt <= 6'd0;
        if (state == S_OP && cur_idx == 5'd2) op_b2 <= bit_val;
        if (state == S_OP && cur_idx == 5'd3) op_rd <= op_b2;
        if (state == S_ADDR) addr_sr <= addr_full[8:0];
        if (state == S_ADDR && cur_idx == 5'd13) begin
          match    <= match_c;
          reg_addr <= addr_full[4:0];
          snap     <= rd_val;
          rd_drive <= op_rd && match_c;
        end
        if (state == S_DATA) data_sr <= wdata[14:0];
      end
      if (fall && rd_drive) begin
        if (bit_idx == 5'd14) begin
          mdio_oen <= 1'b0;
          mdio_out <= 1'b0;
        end else if (bit_idx >= 5'd15 && bit_idx <= 5'd30) begin
          mdio_out <= snap[4'(5'd30 - bit_idx)];
        end else if (bit_idx == 5'd31) begin
          mdio_oen <= 1'b1;
          mdio_out <= 1'b1;
          rd_drive <= 1'b0;
        end
      end
    end
  end

  // Register file writes, reg 0 bit 15 self-clear (a same-cycle write wins) and write report.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 16'h0000;
      rf[0]    <= 16'h1140;
      wr_valid <= 1'b0;
      wr_reg   <= 5'd0;
      wr_data  <= 16'd0;
    end else begin
      wr_valid <= commit;
      if (commit) begin
        wr_reg  <= reg_addr;
        wr_data <= wdata;
      end
      if (commit && reg_addr != 5'd0) rf[reg_addr] <= wdata;
      if (commit && reg_addr == 5'd0) rf[0]     <= wdata;
      else if (rf[0][15])             rf[0][15] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// tb_mdio_phy_responder: drives MDC/MDIO frames like a MAC master and checks replies against a register model.
// Latency: MDC = clk/10; read bits are sampled just before each MDC rise.
// Backpressure: none; the bench paces all traffic through MDC.
module tb_mdio_phy_responder;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        mdc;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_oen;
  logic        link_up;
  logic [15:0] phy_ctrl;
  logic        wr_valid;
  logic [4:0]  wr_reg;
  logic [15:0] wr_data;
  logic        frame_err;

  int n_checks = 0;
  int n_fails  = 0;

  // Event counters sampled on the inactive edge.
  int oen_low_cycles = 0;
  int wr_pulses      = 0;
  int wr_long        = 0;
  int err_pulses     = 0;
  int ctrl_msb_cycles = 0;
  logic prev_wr = 1'b0;

  logic [15:0] model_regs [0:31];

  always #5 clk_clk = ~clk_clk;

  mdio_phy_responder #(
    .PHY_ADDR (5'd1),
    .PRE_LEN  (32),
    .PHY_ID1  (16'h0141),
    .PHY_ID2  (16'h0DD1)
  ) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .mdc         (mdc),
    .mdio_in     (mdio_in),
    .mdio_out    (mdio_out),
    .mdio_oen    (mdio_oen),
    .link_up     (link_up),
    .phy_ctrl    (phy_ctrl),
    .wr_valid    (wr_valid),
    .wr_reg      (wr_reg),
    .wr_data     (wr_data),
    .frame_err   (frame_err)
  );

  // Count line ownership, write pulses (and any pulse longer than one cycle), errors and reg0[15] lifetime.
  always @(negedge clk_clk) begin
    if (!reset_reset) begin
      if (mdio_oen == 1'b0) oen_low_cycles++;
      if (wr_valid) wr_pulses++;
      if (wr_valid && prev_wr) wr_long++;
      if (frame_err) err_pulses++;
      if (phy_ctrl[15]) ctrl_msb_cycles++;
    end
    prev_wr = wr_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_init();
    for (int i = 0; i < 32; i++) model_regs[i] = 16'h0000;
    model_regs[0] = 16'h1140;
  endfunction

  function automatic logic [15:0] model_read(input logic [4:0] r, input logic lk);
    if (r == 5'd1) return lk ? 16'h794D : 16'h7949;
    if (r == 5'd2) return 16'h0141;
    if (r == 5'd3) return 16'h0DD1;
    return model_regs[r];
  endfunction

  // One MDC period: present the bit while MDC is low, sample the line, then hold MDC high.
  task automatic mdc_bit(input logic b, output logic line, output logic oen);
    @(negedge clk_clk);
    mdio_in = b;
    repeat (4) @(negedge clk_clk);
    oen  = mdio_oen;
    line = mdio_oen ? 1'b1 : mdio_out;
    mdc  = 1'b1;
    repeat (5) @(negedge clk_clk);
    mdc  = 1'b0;
  endtask

  // Preamble plus up to 32 frame bits; the master releases MDIO from TA onward on reads.
  task automatic mdio_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] rg, input logic [15:0] wd, input int nbits,
                            output logic [15:0] rd, output logic ta_ok,
                            output logic drv_ok, output logic rel_ok);
    logic [31:0] fr;
    logic        is_rd;
    logic        b;
    logic        s_line;
    logic        s_oen;
    is_rd  = (op == 2'b10);
    fr     = {2'b01, op, phy, rg, 2'b10, wd};
    rd     = 16'h0000;
    ta_ok  = 1'b1;
    drv_ok = 1'b1;
    for (int i = 0; i < pre; i++) mdc_bit(1'b1, s_line, s_oen);
    for (int k = 0; k < nbits; k++) begin
      b  = (is_rd && k >= 14) ? 1'b1 : fr[31];
      fr = fr << 1;
      mdc_bit(b, s_line, s_oen);
      if (k == 14 && s_oen !== 1'b1) ta_ok = 1'b0;
      if (k == 15 && (s_oen !== 1'b0 || s_line !== 1'b0)) ta_ok = 1'b0;
      if (k >= 16) begin
        rd = {rd[14:0], s_line};
        if (s_oen !== 1'b0) drv_ok = 1'b0;
      end
    end
    repeat (6) @(negedge clk_clk);
    rel_ok = (mdio_oen === 1'b1) && (mdio_out === 1'b1);
  endtask

  initial begin
    logic [15:0] rd;
    logic        ta_ok, drv_ok, rel_ok;
    int          o0, w0, e0, c0, pre;
    logic [4:0]  rg, phy;
    logic [15:0] d;
    logic        is_wr, exp_commit;

    mdc = 1'b0; mdio_in = 1'b1; link_up = 1'b1; reset_reset = 1'b1;
    model_init();
    repeat (5) @(negedge clk_clk);
    check_eq("rst_mdio_out",  mdio_out,  1);
    check_eq("rst_mdio_oen",  mdio_oen,  1);
    check_eq("rst_phy_ctrl",  phy_ctrl,  16'h1140);
    check_eq("rst_wr_valid",  wr_valid,  0);
    check_eq("rst_wr_reg",    wr_reg,    0);
    check_eq("rst_wr_data",   wr_data,   0);
    check_eq("rst_frame_err", frame_err, 0);
    reset_reset = 1'b0;
    repeat (5) @(negedge clk_clk);

    // Read PHY ID1.
    mdio_frame(32, 2'b10, 5'd1, 5'd2, 16'h0, 32, rd, ta_ok, drv_ok, rel_ok);
    check_eq("rd2_ta",   ta_ok,  1);
    check_eq("rd2_drv",  drv_ok, 1);
    check_eq("rd2_data", rd,     16'h0141);
    check_eq("rd2_rel",  rel_ok, 1);

    // Write then read back reg 5.
    w0 = wr_pulses;
    mdio_frame(32, 2'b01, 5'd1, 5'd5, 16'hABCD, 32, rd, ta_ok, drv_ok, rel_ok);
    check_eq("wr5_pulse", wr_pulses - w0, 1);
    check_eq("wr5_reg",   wr_reg,  5);
    check_eq("wr5_data",  wr_data, 16'hABCD);
    model_regs[5] = 16'hABCD;
    mdio_frame(32, 2'b10, 5'd1, 5'd5, 16'h0, 32, rd, ta_ok, drv_ok, rel_ok);
    check_eq("rd5_data", rd, model_read(5'd5, link_up));

    // Reg 0 bit 15 self-clears after one cycle.
    c0 = ctrl_msb_cycles;
    mdio_frame(32, 2'b01, 5'd1, 5'd0, 16'h8000, 32, rd, ta_ok, drv_ok, rel_ok);
    check_eq("rst_bit_cycles", ctrl_msb_cycles - c0, 1);
    check_eq("ctrl_after",     phy_ctrl, 16'h0000);
    check_eq("ctrl_wr_data",   wr_data,  16'h8000);
    model_regs[0] = 16'h0000;
    mdio_frame(32, 2'b10, 5'd1, 5'd0, 16'h0, 32, rd, ta_ok, drv_ok, rel_ok);
    check_eq("rd0_data", rd, model_read(5'd0, link_up));

    // Status register reflects link_up and ignores writes.
    link_up = 1'b1;
    mdio_frame(32, 2'b10, 5'd1, 5'd1, 16'h0, 32, rd, ta_ok, drv_ok, rel_ok);
    check_eq("rd1_link1", rd, 16'h794D);
    link_up = 1'b0;
    mdio_frame(32, 2'b10, 5'd1, 5'd1, 16'h0, 32, rd, ta_ok, drv_ok, rel_ok);
    check_eq("rd1_link0", rd, 16'h7949);
    w0 = wr_pulses;
    mdio_frame(32, 2'b01, 5'd1, 5'd1, 16'h1234, 32, rd, ta_ok, drv_ok, rel_ok);
    check_eq("wr1_nopulse", wr_pulses - w0, 0);
    mdio_frame(32, 2'b10, 5'd1, 5'd1, 16'h0, 32, rd, ta_ok, drv_ok, rel_ok);
    check_eq("rd1_unchanged", rd, 16'h7949);

    // Foreign PHY address is silent; OP=11 reports one error.
    o0 = oen_low_cycles; w0 = wr_pulses; e0 = err_pulses;
    mdio_frame(32, 2'b10, 5'd2, 5'd2, 16'h0, 32, rd, ta_ok, drv_ok, rel_ok);
    mdio_frame(32, 2'b01, 5'd2, 5'd6, 16'h5555, 32, rd, ta_ok, drv_ok, rel_ok);
    check_eq("foreign_oen", oen_low_cycles - o0, 0);
    check_eq("foreign_wr",  wr_pulses - w0, 0);
    check_eq("foreign_err", err_pulses - e0, 0);
    mdio_frame(32, 2'b11, 5'd1, 5'd4, 16'h0, 32, rd, ta_ok, drv_ok, rel_ok);
    check_eq("op11_err", err_pulses - e0, 1);
    check_eq("op11_oen", oen_low_cycles - o0, 0);
    check_eq("op11_wr",  wr_pulses - w0, 0);
    mdio_frame(32, 2'b10, 5'd1, 5'd6, 16'h0, 32, rd, ta_ok, drv_ok, rel_ok);
    check_eq("rd6_untouched", rd, model_read(5'd6, link_up));

    // Short preamble is ignored; exact length then works.
    o0 = oen_low_cycles; e0 = err_pulses;
    mdio_frame(31, 2'b10, 5'd1, 5'd2, 16'h0, 32, rd, ta_ok, drv_ok, rel_ok);
    check_eq("pre31_oen", oen_low_cycles - o0, 0);
    check_eq("pre31_err", err_pulses - e0, 0);
    mdio_frame(32, 2'b10, 5'd1, 5'd3, 16'h0, 32, rd, ta_ok, drv_ok, rel_ok);
    check_eq("pre32_data", rd, 16'h0DD1);

    // Randomised traffic against the register model.
    for (int t = 0; t < 16; t++) begin
      rg      = 5'($urandom_range(0, 31));
      d       = 16'($urandom);
      is_wr   = 1'($urandom_range(0, 1));
      phy     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(2, 31)) : 5'd1;
      link_up = 1'($urandom_range(0, 1));
      pre     = int'($urandom_range(32, 40));
      w0 = wr_pulses; o0 = oen_low_cycles;
      if (is_wr) begin
        mdio_frame(pre, 2'b01, phy, rg, d, 32, rd, ta_ok, drv_ok, rel_ok);
        exp_commit = (phy == 5'd1) && (rg == 5'd0 || rg >= 5'd4);
        check_eq("rnd_wr_pulse", wr_pulses - w0, {31'd0, exp_commit});
        if (exp_commit) begin
          check_eq("rnd_wr_reg",  wr_reg,  rg);
          check_eq("rnd_wr_data", wr_data, d);
          model_regs[rg] = (rg == 5'd0) ? (d & 16'h7FFF) : d;
          if (rg == 5'd0) check_eq("rnd_ctrl", phy_ctrl, model_regs[0]);
        end
      end else begin
        mdio_frame(pre, 2'b10, phy, rg, 16'h0, 32, rd, ta_ok, drv_ok, rel_ok);
        if (phy == 5'd1) begin
          check_eq("rnd_rd_ta",   ta_ok, 1);
          check_eq("rnd_rd_data", rd, model_read(rg, link_up));
          check_eq("rnd_rd_rel",  rel_ok, 1);
        end else begin
          check_eq("rnd_rd_silent", oen_low_cycles - o0, 0);
        end
      end
    end
    check_eq("rnd_no_err", err_pulses - e0, 0);

    // Reset in the middle of a read's data phase.
    mdio_frame(32, 2'b01, 5'd1, 5'd5, 16'h5A5A, 32, rd, ta_ok, drv_ok, rel_ok);
    mdio_frame(32, 2'b01, 5'd1, 5'd0, 16'h0100, 32, rd, ta_ok, drv_ok, rel_ok);
    check_eq("pre_rst_ctrl", phy_ctrl, 16'h0100);
    mdio_frame(32, 2'b10, 5'd1, 5'd5, 16'h0, 20, rd, ta_ok, drv_ok, rel_ok);
    check_eq("mid_drv", drv_ok, 1);
    check_eq("mid_oen", mdio_oen, 0);
    reset_reset = 1'b1;
    @(negedge clk_clk);
    check_eq("mid_rst_oen",  mdio_oen, 1);
    check_eq("mid_rst_out",  mdio_out, 1);
    check_eq("mid_rst_ctrl", phy_ctrl, 16'h1140);
    repeat (2) @(negedge clk_clk);
    reset_reset = 1'b0;
    model_init();
    repeat (5) @(negedge clk_clk);
    link_up = 1'b1;
    mdio_frame(32, 2'b10, 5'd1, 5'd5, 16'h0, 32, rd, ta_ok, drv_ok, rel_ok);
    check_eq("post_rst_rd5", rd, model_read(5'd5, link_up));
    mdio_frame(32, 2'b10, 5'd1, 5'd0, 16'h0, 32, rd, ta_ok, drv_ok, rel_ok);
    check_eq("post_rst_rd0", rd, model_read(5'd0, link_up));

    check_eq("wr_single_cycle", wr_long, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mdio_phy_responder.md
# mdio_phy_responder

Clause 22 MDIO responder (management slave) running on the system clock. It oversamples the MDC/MDIO lines driven by the TSE MAC's MDIO master, decodes read and write frames addressed to its PHY address, and serves a 32 x 16-bit PHY register file. It acts as the PHY-side end of the management link for board bring-up, loopback benches and PHY emulation.

## Interface

Parameters:
- PHY_ADDR, 5'd1: PHY address this responder answers to.
- PRE_LEN, 32: consecutive preamble ones required before ST (1..32).
- PHY_ID1, 16'h0141: reset/read value of reg 2 (read-only).
- PHY_ID2, 16'h0DD1: reset/read value of reg 3 (read-only).

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  synchronous, active-high reset.
- mdc  in  1  MDC from the MAC, asynchronous to clk_clk.
- mdio_in  in  1  MDIO line value, asynchronous.
- mdio_out  out  1  value driven onto MDIO when enabled.
- mdio_oen  out  1  output enable, active low; 1 means released.
- link_up  in  1  live link status, reflected in reg 1 bit 2.
- phy_ctrl  out  16  current value of reg 0.
- wr_valid  out  1  one-cycle pulse on a committed register write.
- wr_reg  out  5  register address of the last committed write.
- wr_data  out  16  data of the last committed write.
- frame_err  out  1  one-cycle pulse on a bad ST or OP.

## Operation

- mdc and mdio_in each pass through a 2-FF synchronizer plus a third stage used for edge detect. Both paths have the same delay, so they stay aligned.
- rise = sync mdc 0->1 and fall = sync mdc 1->0. Each is a one-cycle strobe. All protocol sampling happens on rise only.
- Frame bit index k counts from 0 at the first ST bit: ST 0-1, OP 2-3, PHYAD 4-8, REGAD 9-13 (MSB first), TA 14-15, DATA 16-31.
- States: IDLE, ST, OP, ADDR, TA, DATA.
- IDLE: the preamble counter counts consecutive sampled 1s and saturates at PRE_LEN. A sampled 0 clears it. When the counter is at PRE_LEN, that 0 is ST bit 0 and the FSM goes to ST.
- ST: the bit must be 1. A 0 causes a frame_err pulse and a return to IDLE.
- OP: 10 is a read and 01 is a write. 00 or 11 causes a frame_err pulse and IDLE.
- ADDR: shifts in PHYAD and REGAD.
  - match = (PHYAD == PHY_ADDR).
  - On the rise that samples bit 13, the read data is snapshotted from the register file.
- TA then DATA: the bit counter runs through k=31, then the FSM returns to IDLE with the preamble count at 0.
- A mismatched PHYAD follows the same path silently: the line is never driven and nothing is written.
- Read with match:
  - On the fall after bit 14 is sampled: mdio_oen=0, mdio_out=0.
  - On the fall after bit 15+j is sampled: mdio_out = snapshot[15-j], for j=0..15.
  - On the fall after bit 31 is sampled: mdio_oen=1, mdio_out=1.
- Write with match: bits 16-31 are shifted into the data register. On the rise sampling bit 31, the write commits in the same clk cycle as the decision. wr_valid pulses the next cycle and wr_reg/wr_data update with it. Writes to RO registers are dropped without a pulse.
- Register map:
  - reg 0: RW, reset 16'h1140. Bit 15 self-clears one cycle after being written as 1; wr_data still shows the 1.
  - reg 1: RO, reads 16'h7949 with bit 2 = link_up.
  - reg 2 and reg 3: RO, PHY_ID1 and PHY_ID2.
  - reg 4-31: RW, reset 0.

## Timing

- Reset values: mdio_out=1, mdio_oen=1, phy_ctrl=16'h1140, wr_valid=0, wr_reg=0, wr_data=0, frame_err=0. FSM in IDLE with preamble count 0; register file at its defaults.
- MDC requirement: high and low phases each at least 4 clk_clk cycles.
- Edge latency: rise/fall assert 3 cycles after the raw mdc transition. mdio_out/mdio_oen update 1 cycle after the fall strobe, so drive lags raw MDC falling by 4 cycles.
- wr_valid asserts 1 cycle after the bit-31 rise strobe, for exactly 1 cycle.
- Reset mid-frame: the line is released in the cycle after reset is sampled, and any partial write is discarded.
- A rise and a fall can never coincide, because MDC phases are at least 4 cycles.
- A write to reg 0 and a bit-15 self-clear in the same cycle: the write wins.
- A frame with exactly PRE_LEN ones is accepted; PRE_LEN-1 ones are not. Extra preamble ones are accepted.
- The read snapshot is stable: a link_up change during DATA does not alter bits already being shifted.

## Test plan

- Read reg 2 at PHY_ADDR=1, 32-bit preamble, MDC = clk/10 -> TA second bit 0 with oen=0, data 16'h0141 MSB first, oen=1 after bit 31.
- Write 16'hABCD to reg 5, then read reg 5 -> wr_valid single pulse with wr_reg=5 and wr_data=16'hABCD; readback 16'hABCD.
- Write 16'h8000 to reg 0 -> phy_ctrl=16'h8000 for 1 cycle, then 16'h0000; reg 0 reads 0.
- Read reg 1 with link_up=1, then 0 -> 16'h794D, then 16'h7949. Write to reg 1 -> no wr_valid, value unchanged.
- Frame to PHYAD 2 while PHY_ADDR=1, plus an OP=11 frame -> mdio_oen stays 1 throughout. No wr_valid. frame_err pulses once, for the OP=11 frame only.
- 31-bit preamble read, then reset asserted mid-DATA of a valid read:
  - 31-bit preamble read: ignored, no drive.
  - Reset mid-DATA: oen=1 next cycle; phy_ctrl=16'h1140, reg 5=0.
